cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Control unit for the single-cycle CPU: owns the program counter, fetches one instruction per cycle from an asynchronous-read program memory, and decodes it into the enable/select strobes that drive the datapath (register file, data memory, ALU, accumulator). It also runs conditional branches on the accumulator zero flag, keeps a small call/return stack, and supports halt/continue. It sits beside the datapath in the CPU top level; datapath control inputs connect 1:1 to this block's outputs.

## Interface
- WIDTH, 8: data/operand width
- IWIDTH, 5: opcode width; ALU op field is IWIDTH-1 bits
- PC_WIDTH, 8: program counter / program memory address width
- STACK_DEPTH, 4: return-address stack entries (power of two)
- REG_F_SEL_SIZE, 4; IN_B_SEL_SIZE, 2

- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- INSTR  in  IWIDTH+IN_B_SEL_SIZE+WIDTH (15)  instruction at P_MEM_ADDR: [14:10] opcode, [9:8] mode, [7:0] operand
- ACC_ZERO  in  1  high when accumulator == 0
- CONT  in  1  resume request while halted
- P_MEM_ADDR  out  PC_WIDTH  current PC
- REG_F_SEL  out  4, EN_REG_F  out  1, D_MEM_ADDR  out  WIDTH, D_MEM_ADDR_MODE  out  1, EN_D_MEM  out  1, IN_B_SEL  out  2, IMM  out  WIDTH, ALU_OUT  out  IWIDTH-1, EN_ACC  out  1: datapath controls
- HALTED  out  1  high in HALT state
- ERR  out  1  sticky stack-fault flag

## Operation
- States: RUN, HALT. Reset -> RUN, PC=0, SP=0, ERR=0.
- Common decode (always): IMM=D_MEM_ADDR=operand; REG_F_SEL=operand[3:0]; IN_B_SEL=mode; D_MEM_ADDR_MODE=mode[0]&mode[1] for ALU ops, =mode[0] for STM.
- Opcode[4]=0: ALU op. ALU_OUT=opcode[3:0], EN_ACC=1; PC+1.
- 10000 NOP: no enables; PC+1.
- 10001 STR: EN_REG_F=1 (ACC -> Rn); PC+1.
- 10010 STM: EN_D_MEM=1; address = operand (mode[0]=0) or R[operand[3:0]] (mode[0]=1); PC+1.
- 10011 JMP: PC=operand[PC_WIDTH-1:0].
- 10100 JZ / 10101 JNZ: PC=operand if ACC_ZERO / !ACC_ZERO, else PC+1.
- 10110 CALL: push PC+1, SP+1, PC=operand. Stack full (SP==STACK_DEPTH) -> no push, ERR=1, -> HALT, PC unchanged.
- 10111 RET: SP-1, PC=popped. Stack empty -> ERR=1, -> HALT, PC unchanged.
- 11111 HLT: -> HALT, PC unchanged.
- Other opcodes: treated as NOP.
- HALT: all enables (EN_ACC, EN_REG_F, EN_D_MEM) forced 0; PC holds. CONT=1 and ERR=0 -> RUN, PC+1. CONT ignored when ERR=1; only reset clears ERR.
- PC arithmetic modulo 2^PC_WIDTH (wraps max -> 0).

## Timing
- Single-cycle: decode outputs combinational from INSTR, ACC_ZERO, state; PC/SP/state/ERR update on rising CLK.
- While RST_N=0: PC=0, SP=0, HALTED=0, ERR=0, all enables 0 (gated by RST_N).
- Branch/call/return take effect next cycle; no delay slot.
- JZ/JNZ use ACC_ZERO of the current cycle (value before any write this cycle).
- CONT in same cycle as entering HALT is ignored; sampled only while already in HALT.
- Reset mid-CALL/RET: stack contents discarded (SP=0).

## Structure
- Shared package cpu_pkg: opcode constants (OP_NOP..OP_HLT), field bit positions, IN_B_SEL encodings (IMM=00, REG=01, MEM=1x), state encoding.
- One sub-module: cpu_ret_stack (LIFO, push/pop, full/empty, SP). Decode and PC logic stay in cpu_ctrl.

## Test plan
- Reset, INSTR=ALU op 0x02 mode 00 operand 0x05 -> ALU_OUT=2, EN_ACC=1, IMM=0x05, IN_B_SEL=00; P_MEM_ADDR 0 -> 1.
- JZ 0x40 with ACC_ZERO=1 -> PC=0x40; with ACC_ZERO=0 -> PC+1; JNZ mirror case.
- CALL 0x10 at PC=0x03, then RET -> PC 0x10 then 0x04; nested 4 calls return in LIFO order.
- 5th nested CALL -> ERR=1, HALTED=1, PC held, no enables; CONT ignored; RST_N low clears.
- HLT at PC=0x07 -> HALTED=1, EN_* =0; CONT pulse -> RUN, PC=0x08.
- STM mode 01 operand 0x3 -> EN_D_MEM=1, D_MEM_ADDR_MODE=1, REG_F_SEL=3; JMP at PC=0xFF with PC+1 wrap test: NOP at 0xFF -> PC=0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU control unit: opcodes, instruction
// field positions, operand-B select encodings and the control state encoding.
package cpu_pkg;

    localparam int OPC_MSB  = 14;
    localparam int OPC_LSB  = 10;
    localparam int MODE_MSB = 9;
    localparam int MODE_LSB = 8;
    localparam int OPD_MSB  = 7;
    localparam int OPD_LSB  = 0;

    localparam logic [4:0] OP_NOP  = 5'b10000;
    localparam logic [4:0] OP_STR  = 5'b10001;
    localparam logic [4:0] OP_STM  = 5'b10010;
    localparam logic [4:0] OP_JMP  = 5'b10011;
    localparam logic [4:0] OP_JZ   = 5'b10100;
    localparam logic [4:0] OP_JNZ  = 5'b10101;
    localparam logic [4:0] OP_CALL = 5'b10110;
    localparam logic [4:0] OP_RET  = 5'b10111;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    // Operand-B source; any value with bit 1 set selects data memory.
    localparam logic [1:0] IN_B_IMM = 2'b00;
    localparam logic [1:0] IN_B_REG = 2'b01;
    localparam logic [1:0] IN_B_MEM = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    function automatic logic is_alu_op(input logic [4:0] opc);
        return ~opc[4];
    endfunction

endpackage

// File: rtl/cpu_ret_stack.sv
// Return-address LIFO for CALL/RET. Push is refused when full, pop when empty;
// the stack pointer counts stored entries (0..DEPTH).
module cpu_ret_stack #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] top_data,
    output logic          full,
    output logic          empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [SPW-1:0] sp_r;
    logic [SPW-1:0] sp_dec_s;
    logic [DW-1:0]  mem_r [DEPTH];

    assign sp_dec_s = sp_r - SPW'(1);
    assign full     = (sp_r == SPW'(DEPTH));
    assign empty    = (sp_r == {SPW{1'b0}});
    assign top_data = mem_r[sp_dec_s[AW-1:0]];

    // Stack pointer and entry storage; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {SPW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[sp_r[AW-1:0]] <= push_data;
            sp_r                <= sp_r + SPW'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_dec_s;
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Control unit: program counter, instruction decode into datapath strobes,
// conditional branches, call/return via cpu_ret_stack, and halt/continue.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int IWIDTH         = 5,
    parameter int PC_WIDTH       = 8,
    parameter int STACK_DEPTH    = 4,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [IWIDTH+IN_B_SEL_SIZE+WIDTH-1:0] instr,
    input  logic                                  acc_zero,
    input  logic                                  cont,
    output logic [PC_WIDTH-1:0]                   p_mem_addr,
    output logic [REG_F_SEL_SIZE-1:0]             reg_f_sel,
    output logic                                  en_reg_f,
    output logic [WIDTH-1:0]                      d_mem_addr,
    output logic                                  d_mem_addr_mode,
    output logic                                  en_d_mem,
    output logic [IN_B_SEL_SIZE-1:0]              in_b_sel,
    output logic [WIDTH-1:0]                      imm,
    output logic [IWIDTH-2:0]                     alu_out,
    output logic                                  en_acc,
    output logic                                  halted,
    output logic                                  err
);
    localparam int IW = IWIDTH + IN_B_SEL_SIZE + WIDTH;

    logic [IWIDTH-1:0]        opcode_s;
    logic [IN_B_SEL_SIZE-1:0] mode_s;
    logic [WIDTH-1:0]         operand_s;

    state_t              state_r, state_next_s;
    logic [PC_WIDTH-1:0] pc_r, pc_next_s, pc_inc_s, target_s, ret_addr_s;
    logic                err_r, err_set_s;
    logic                en_acc_s, en_reg_f_s, en_d_mem_s, dmam_s;
    logic                push_s, pop_s, stk_full_s, stk_empty_s;

    assign opcode_s  = instr[IW-1 -: IWIDTH];
    assign mode_s    = instr[WIDTH +: IN_B_SEL_SIZE];
    assign operand_s = instr[WIDTH-1:0];
    assign pc_inc_s  = pc_r + PC_WIDTH'(1);
    assign target_s  = operand_s[PC_WIDTH-1:0];

    cpu_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .DW    (PC_WIDTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top_data  (ret_addr_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // Decode and next-PC/next-state selection; enables only fire in RUN.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        err_set_s    = 1'b0;
        en_acc_s     = 1'b0;
        en_reg_f_s   = 1'b0;
        en_d_mem_s   = 1'b0;
        dmam_s       = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        if (is_alu_op(opcode_s)) begin
            dmam_s = mode_s[0] & mode_s[1];
        end else if (opcode_s == OP_STM) begin
            dmam_s = mode_s[0];
        end else begin
            dmam_s = 1'b0;
        end
        case (state_r)
            ST_RUN: begin
                if (is_alu_op(opcode_s)) begin
                    en_acc_s  = 1'b1;
                    pc_next_s = pc_inc_s;
                end else begin
                    case (opcode_s)
                        OP_STR: begin
                            en_reg_f_s = 1'b1;
                            pc_next_s  = pc_inc_s;
                        end
                        OP_STM: begin
                            en_d_mem_s = 1'b1;
                            pc_next_s  = pc_inc_s;
                        end
                        OP_JMP:  pc_next_s = target_s;
                        OP_JZ:   pc_next_s = acc_zero ? target_s : pc_inc_s;
                        OP_JNZ:  pc_next_s = acc_zero ? pc_inc_s : target_s;
                        OP_CALL: begin
                            if (stk_full_s) begin
                                err_set_s    = 1'b1;
                                state_next_s = ST_HALT;
                            end else begin
                                push_s    = 1'b1;
                                pc_next_s = target_s;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty_s) begin
                                err_set_s    = 1'b1;
                                state_next_s = ST_HALT;
                            end else begin
                                pop_s     = 1'b1;
                                pc_next_s = ret_addr_s;
                            end
                        end
                        OP_HLT:  state_next_s = ST_HALT;
                        default: pc_next_s = pc_inc_s;
                    endcase
                end
            end
            ST_HALT: begin
                if (cont && !err_r) begin
                    state_next_s = ST_RUN;
                    pc_next_s    = pc_inc_s;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: begin
                state_next_s = ST_HALT;
                err_set_s    = 1'b1;
            end
        endcase
    end

    // PC, control state and sticky stack-fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= {PC_WIDTH{1'b0}};
            state_r <= ST_RUN;
            err_r   <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
            err_r   <= err_r | err_set_s;
        end
    end

    assign p_mem_addr      = pc_r;
    assign imm             = operand_s;
    assign d_mem_addr      = operand_s;
    assign reg_f_sel       = operand_s[REG_F_SEL_SIZE-1:0];
    assign in_b_sel        = mode_s;
    assign alu_out         = opcode_s[IWIDTH-2:0];
    assign d_mem_addr_mode = dmam_s;
    assign en_acc          = en_acc_s & rst_n;
    assign en_reg_f        = en_reg_f_s & rst_n;
    assign en_d_mem        = en_d_mem_s & rst_n;
    assign halted          = (state_r == ST_HALT);
    assign err             = err_r;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: directed per-cycle vectors push hand-computed
// expectations; a negedge monitor pops and compares each cycle's outputs.
module tb_cpu_ctrl;

    typedef struct packed {
        logic [7:0] pc;
        logic       halted;
        logic       err;
        logic [2:0] en;        // {en_acc, en_reg_f, en_d_mem}
        logic       dp;        // also check datapath fields
        logic [3:0] alu;
        logic [7:0] imm;
        logic [1:0] ibs;
        logic       dmam;
        logic [3:0] rfs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] instr = 15'h0000;
    logic        acc_zero = 1'b0;
    logic        cont = 1'b0;
    logic [7:0]  p_mem_addr, d_mem_addr, imm;
    logic [3:0]  reg_f_sel, alu_out;
    logic [1:0]  in_b_sel;
    logic        en_reg_f, d_mem_addr_mode, en_d_mem, en_acc, halted, err;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    stim_done = 1'b0;

    always #5 clk = ~clk;

    cpu_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr           (instr),
        .acc_zero        (acc_zero),
        .cont            (cont),
        .p_mem_addr      (p_mem_addr),
        .reg_f_sel       (reg_f_sel),
        .en_reg_f        (en_reg_f),
        .d_mem_addr      (d_mem_addr),
        .d_mem_addr_mode (d_mem_addr_mode),
        .en_d_mem        (en_d_mem),
        .in_b_sel        (in_b_sel),
        .imm             (imm),
        .alu_out         (alu_out),
        .en_acc          (en_acc),
        .halted          (halted),
        .err             (err)
    );

    function automatic logic [14:0] mk(input logic [4:0] op, input logic [1:0] m, input logic [7:0] opd);
        return {op, m, opd};
    endfunction

    task automatic step_dp(input string nm, input logic r, input logic [14:0] ins,
                           input logic az, input logic ct, input logic [7:0] pc,
                           input logic h, input logic e, input logic [2:0] en,
                           input logic dp, input logic [3:0] alu, input logic [7:0] im,
                           input logic [1:0] ibs, input logic dmam, input logic [3:0] rfs);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n    = r;
        instr    = ins;
        acc_zero = az;
        cont     = ct;
        x = '{pc: pc, halted: h, err: e, en: en, dp: dp, alu: alu, imm: im,
              ibs: ibs, dmam: dmam, rfs: rfs};
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic r, input logic [14:0] ins,
                        input logic az, input logic ct, input logic [7:0] pc,
                        input logic h, input logic e, input logic [2:0] en);
        step_dp(nm, r, ins, az, ct, pc, h, e, en, 1'b0, 4'h0, 8'h00, 2'b00, 1'b0, 4'h0);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x;
            string nm;
            logic  ok;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            ok = (p_mem_addr == x.pc) && (halted == x.halted) && (err == x.err) &&
                 ({en_acc, en_reg_f, en_d_mem} == x.en);
            if (x.dp) begin
                ok = ok && (imm == x.imm) && (d_mem_addr == x.imm) && (in_b_sel == x.ibs) &&
                     (d_mem_addr_mode == x.dmam) && (reg_f_sel == x.rfs);
                if (x.en[2]) ok = ok && (alu_out == x.alu);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got pc=%h h=%b e=%b en=%b alu=%h imm=%h ibs=%b dmam=%b rfs=%h / exp pc=%h h=%b e=%b en=%b alu=%h imm=%h ibs=%b dmam=%b rfs=%h",
                         nm, p_mem_addr, halted, err, {en_acc, en_reg_f, en_d_mem}, alu_out,
                         imm, in_b_sel, d_mem_addr_mode, reg_f_sel,
                         x.pc, x.halted, x.err, x.en, x.alu, x.imm, x.ibs, x.dmam, x.rfs);
            end
        end
    end

    initial begin
        logic [14:0] nop, alu2;
        nop  = mk(5'b10000, 2'b00, 8'h00);
        alu2 = mk(5'b00010, 2'b00, 8'h05);
        // Reset: ALU instruction present but enables gated off
        step("reset",      1'b0, alu2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        step_dp("alu_02",  1'b1, alu2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b100,
                1'b1, 4'h2, 8'h05, 2'b00, 1'b0, 4'h5);
        step("nop_pc1",    1'b1, nop, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 3'b000);
        step_dp("alu_0a_m3", 1'b1, mk(5'b01010, 2'b11, 8'h33), 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 3'b100,
                1'b1, 4'hA, 8'h33, 2'b11, 1'b1, 4'h3);
        step("call_10",    1'b1, mk(5'b10110, 2'b00, 8'h10), 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 3'b000);
        step("ret",        1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 3'b000);
        step("jz_taken",   1'b1, mk(5'b10100, 2'b00, 8'h40), 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 3'b000);
        step("jz_nottk",   1'b1, mk(5'b10100, 2'b00, 8'h50), 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 3'b000);
        step("jnz_taken",  1'b1, mk(5'b10101, 2'b00, 8'h60), 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 3'b000);
        step("jnz_nottk",  1'b1, mk(5'b10101, 2'b00, 8'h70), 1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 3'b000);
        step("str",        1'b1, mk(5'b10001, 2'b00, 8'h07), 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 3'b010);
        step_dp("stm_reg", 1'b1, mk(5'b10010, 2'b01, 8'h03), 1'b0, 1'b0, 8'h62, 1'b0, 1'b0, 3'b001,
                1'b1, 4'h0, 8'h03, 2'b01, 1'b1, 4'h3);
        step_dp("stm_dir", 1'b1, mk(5'b10010, 2'b00, 8'h20), 1'b0, 1'b0, 8'h63, 1'b0, 1'b0, 3'b001,
                1'b1, 4'h0, 8'h20, 2'b00, 1'b0, 4'h0);
        // Four nested calls then LIFO returns
        step("call_80",    1'b1, mk(5'b10110, 2'b00, 8'h80), 1'b0, 1'b0, 8'h64, 1'b0, 1'b0, 3'b000);
        step("call_90",    1'b1, mk(5'b10110, 2'b00, 8'h90), 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 3'b000);
        step("call_a0",    1'b1, mk(5'b10110, 2'b00, 8'hA0), 1'b0, 1'b0, 8'h90, 1'b0, 1'b0, 3'b000);
        step("call_b0",    1'b1, mk(5'b10110, 2'b00, 8'hB0), 1'b0, 1'b0, 8'hA0, 1'b0, 1'b0, 3'b000);
        step("ret4",       1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'hB0, 1'b0, 1'b0, 3'b000);
        step("ret3",       1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 3'b000);
        step("ret2",       1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'h91, 1'b0, 1'b0, 3'b000);
        step("ret1",       1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 3'b000);
        step("ret_empty",  1'b1, mk(5'b10111, 2'b00, 8'h00), 1'b0, 1'b0, 8'h65, 1'b0, 1'b0, 3'b000);
        step("uflow_halt", 1'b1, alu2, 1'b0, 1'b1, 8'h65, 1'b1, 1'b1, 3'b000);
        step("uflow_cont", 1'b1, alu2, 1'b0, 1'b1, 8'h65, 1'b1, 1'b1, 3'b000);
        step("rst_clr1",   1'b0, nop, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        // Overflow on the fifth nested call
        step("o_call10",   1'b1, mk(5'b10110, 2'b00, 8'h10), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        step("o_call20",   1'b1, mk(5'b10110, 2'b00, 8'h20), 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 3'b000);
        step("o_call30",   1'b1, mk(5'b10110, 2'b00, 8'h30), 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 3'b000);
        step("o_call40",   1'b1, mk(5'b10110, 2'b00, 8'h40), 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 3'b000);
        step("o_call50",   1'b1, mk(5'b10110, 2'b00, 8'h50), 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 3'b000);
        step("oflow_halt", 1'b1, mk(5'b10010, 2'b00, 8'h01), 1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 3'b000);
        step("oflow_cont", 1'b1, alu2, 1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 3'b000);
        step("rst_clr2",   1'b0, nop, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        // HLT / CONT
        step("jmp_07",     1'b1, mk(5'b10011, 2'b00, 8'h07), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        step("hlt",        1'b1, mk(5'b11111, 2'b00, 8'h00), 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 3'b000);
        step("halt_hold",  1'b1, alu2, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 3'b000);
        step("halt_cont",  1'b1, alu2, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 3'b000);
        step("resumed",    1'b1, nop, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 3'b000);
        // Wrap and undefined opcode
        step("jmp_ff",     1'b1, mk(5'b10011, 2'b00, 8'hFF), 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 3'b000);
        step("nop_ff",     1'b1, nop, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 3'b000);
        step("undef_op",   1'b1, mk(5'b11000, 2'b00, 8'h12), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000);
        step("after_undef", 1'b1, nop, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 3'b000);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            checks++;
            errors++;
            $display("FAIL timeout: pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
